// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues single-outstanding word fetches and
// buffers returned instructions with their PCs for decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] redirect_imm,
  output logic        misalign_err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic               misalign_q, misalign_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]        instr_mem_q [DEPTH];
  logic [31:0]        pc_mem_q    [DEPTH];

  logic [31:0]        target;
  logic               fire;
  logic               push;
  logic               pop;

  assign target = redirect_pc + redirect_imm;
  assign fire   = imem_req & imem_gnt;
  // A redirect cancels both the response capture and any decode consume.
  assign push   = (state_q == S_WAIT) & imem_rvalid & ~redirect;
  assign pop    = instr_valid & instr_ready & ~redirect;

  assign imem_addr    = fetch_pc_q;
  assign instr_valid  = (count_q != '0);
  assign instr        = instr_mem_q[rd_ptr_q];
  assign instr_pc     = pc_mem_q[rd_ptr_q];
  assign opcode       = instr[6:0];
  assign misalign_err = misalign_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:   if (fire) state_d = S_WAIT;
      S_WAIT:  begin
        if (imem_rvalid)   state_d = S_RUN;
        else if (redirect) state_d = S_DROP;
      end
      S_DROP:  if (imem_rvalid) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    imem_req = 1'b0;
    if ((state_q == S_RUN) && (count_q < CNT_W'(DEPTH)) && !misalign_q && !redirect && rst_n)
      imem_req = 1'b1;
  end

  // PC, error flag and FIFO bookkeeping
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    misalign_d = misalign_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (redirect) begin
      fetch_pc_d = target;
      misalign_d = (target[1:0] != 2'b00);
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (fire) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      misalign_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage feeding the decode/immediate-generation path of the RV32I core. It holds the program counter and issues word fetches to instruction memory over a request/grant/response handshake, buffering returned instructions in a small FIFO. It presents the instruction, its PC and its opcode field to decode, and accepts branch redirects whose target it computes as branch PC plus the sign-extended immediate. Misaligned branch targets raise an error flag.

## Interface
- RESET_PC, 32'h0000_0000: PC fetched first after reset; bits[1:0] must be 0.
- DEPTH, 2: instruction FIFO entries; power of two, ≥2.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch byte address, word-aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  fetched instruction.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode consumes head.
- instr  out  32  head instruction.
- instr_pc  out  32  head instruction's PC.
- opcode  out  7  instr[6:0], to immediate generator.
- redirect  in  1  taken branch, one-cycle pulse.
- redirect_pc  in  32  PC of the branch.
- redirect_imm  in  32  sign-extended branch immediate (ImmExt).
- misalign_err  out  1  sticky: last redirect target not word-aligned.

## Operation
- State: fetch_pc (32b), FIFO of {instr, pc} with count 0..DEPTH, FSM {RUN, WAIT, DROP}, misalign_err.
- Reset (async, rst_n=0): fetch_pc=RESET_PC, FIFO empty, FSM=RUN, misalign_err=0, so imem_req=0, instr_valid=0.
- imem_req = (FSM==RUN) & (count < DEPTH) & ~misalign_err & ~redirect; imem_addr = fetch_pc.
- RUN: on imem_req & imem_gnt → FSM=WAIT, latch req_pc=fetch_pc, fetch_pc += 4 (mod 2^32, wraps 0xFFFF_FFFC→0).
- Ungranted request may be retracted or re-addressed; memory must tolerate this.
- WAIT: on imem_rvalid → push {imem_rdata, req_pc}, FSM=RUN. imem_rvalid outside WAIT is ignored.
- DROP: on imem_rvalid → discard data, FSM=RUN.
- Pop when instr_valid & instr_ready. Push and pop same cycle: count unchanged. Push never occurs when full (issue gated on count).
- Redirect (highest priority): target = redirect_pc + redirect_imm, 32-bit wrap.
  - FIFO flushed (count=0); any pop that cycle is void.
  - FSM: WAIT → DROP; WAIT with imem_rvalid same cycle → RUN, data discarded; DROP stays DROP unless imem_rvalid, then RUN; RUN stays RUN.
  - target[1:0]==0: fetch_pc=target, misalign_err=0.
  - target[1:0]!=0: misalign_err=1, fetch_pc=target unchanged; no further requests until next aligned redirect or reset.
- At most one outstanding request at any time.

## Timing
- First imem_req in the first clk edge cycle after rst_n deasserts (combinational from reset state).
- gnt in cycle N, rvalid earliest N+1; instr_valid registered, earliest cycle after rvalid.
- Next request earliest cycle after rvalid; peak throughput one instruction per 2 cycles with 1-cycle memory.
- Redirect in cycle N (FSM RUN/ungranted): imem_req with imem_addr=target in N+1.
- Redirect with outstanding request: target request in cycle after the stale rvalid.
- instr, instr_pc, opcode are valid only when instr_valid=1; stable while instr_valid & ~instr_ready.
- rst_n assertion mid-transaction: immediate return to reset state; a subsequent stale rvalid arrives in RUN and is ignored.

## Test plan
- Reset, RESET_PC=0x0, gnt=1, 1-cycle memory returning addr as data → instr_pc 0x0,0x4,0x8 in order, instr_valid every 2nd cycle, opcode=instr[6:0].
- Hold instr_ready=0 → after 2 instructions buffered imem_req stays 0; release → both drain in order, fetch resumes at 0x8.
- Outstanding fetch at 0x100, redirect_pc=0x100, redirect_imm=0xFFFF_FFF8 → stale rvalid dropped, FIFO empty, next imem_addr=0xF8.
- Redirect same cycle as rvalid and pop with 2 entries buffered → all discarded, next imem_addr=target, no stale instr_valid.
- redirect_pc=0x100, redirect_imm=0x2 → misalign_err=1, imem_req held 0; aligned redirect to 0x200 → err clears, fetch at 0x200.
- fetch_pc=0xFFFF_FFFC fetch → next imem_addr 0x0; rst_n pulsed while in WAIT → outputs reset, late rvalid ignored, fetch restarts at RESET_PC.
